// File: rtl/banco_a_scan.sv
// Banco A register bank plus scan controller driving a 14:1 read multiplexer select.
// Latency: writes visible 1 cycle after the write edge; first scanned word 1 cycle after start.
// Backpressure: sel/valid hold while ready is low; writes are rejected (wr_err) while a scan runs.
module banco_a_scan #(
  parameter int WIDTH    = 16,
  parameter int LAST_SEL = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             abort,
  input  logic             ready,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
  output logic [WIDTH-1:0] reg8,
  output logic [WIDTH-1:0] reg9,
  output logic [WIDTH-1:0] reg10,
  output logic [WIDTH-1:0] reg11,
  output logic [WIDTH-1:0] reg12,
  output logic [WIDTH-1:0] reg13,
  output logic [3:0]       sel,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             wr_err
);

  // Out-of-range scan lengths fold to the last real register.
  localparam logic [3:0] LAST = (LAST_SEL > 13) ? 4'd13 :
                                (LAST_SEL < 0)  ? 4'd0  : 4'(LAST_SEL);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_d;
  logic             done_d;
  logic             wr_ok, wr_bad;
  logic [WIDTH-1:0] bank [14];

  // A write only lands when the bank is not being scanned and the address exists.
  assign wr_ok  = wr_en && (wr_addr <= 4'd13) && (state_q == IDLE);
  assign wr_bad = wr_en && !wr_ok;

  // State, select and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel     <= 4'd0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      done    <= done_d;
      wr_err  <= wr_bad;
    end
  end

  // Next-state: start leaves IDLE; abort or the final handshake return to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (abort || (ready && (sel == LAST))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next select and done pulse; abort wins over a simultaneous handshake.
  always_comb begin
    sel_d  = sel;
    done_d = 1'b0;
    case (state_q)
      IDLE: sel_d = 4'd0;
      SCAN: begin
        if (abort) begin
          sel_d = 4'd0;
        end else if (ready) begin
          if (sel == LAST) begin
            sel_d  = 4'd0;
            done_d = 1'b1;
          end else begin
            sel_d = sel + 4'd1;
          end
        end
      end
      default: sel_d = 4'd0;
    endcase
  end

  // Register bank: cleared on reset, loaded by accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 14; i++) bank[i] <= '0;
    end else if (wr_ok) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // valid and busy are both decoded straight from the state flop.
  assign valid = (state_q == SCAN);
  assign busy  = (state_q == SCAN);

  assign reg0  = bank[0];
  assign reg1  = bank[1];
  assign reg2  = bank[2];
  assign reg3  = bank[3];
  assign reg4  = bank[4];
  assign reg5  = bank[5];
  assign reg6  = bank[6];
  assign reg7  = bank[7];
  assign reg8  = bank[8];
  assign reg9  = bank[9];
  assign reg10 = bank[10];
  assign reg11 = bank[11];
  assign reg12 = bank[12];
  assign reg13 = bank[13];

endmodule

// File: tb/tb_banco_a_scan.sv
// Bench for banco_a_scan: a full-length instance (a) and a LAST_SEL=4 instance (b) share stimulus.
module tb_banco_a_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, start, abort, ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  logic [15:0] ra [14];
  logic [15:0] rb [14];
  logic [3:0]  sela, selb;
  logic        va, vb, ba, bb, da, db, ea, eb;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  banco_a_scan #(.WIDTH(16), .LAST_SEL(13)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .ready(ready),
    .reg0(ra[0]), .reg1(ra[1]), .reg2(ra[2]), .reg3(ra[3]), .reg4(ra[4]),
    .reg5(ra[5]), .reg6(ra[6]), .reg7(ra[7]), .reg8(ra[8]), .reg9(ra[9]),
    .reg10(ra[10]), .reg11(ra[11]), .reg12(ra[12]), .reg13(ra[13]),
    .sel(sela), .valid(va), .busy(ba), .done(da), .wr_err(ea));

  banco_a_scan #(.WIDTH(16), .LAST_SEL(4)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .ready(ready),
    .reg0(rb[0]), .reg1(rb[1]), .reg2(rb[2]), .reg3(rb[3]), .reg4(rb[4]),
    .reg5(rb[5]), .reg6(rb[6]), .reg7(rb[7]), .reg8(rb[8]), .reg9(rb[9]),
    .reg10(rb[10]), .reg11(rb[11]), .reg12(rb[12]), .reg13(rb[13]),
    .sel(selb), .valid(vb), .busy(bb), .done(db), .wr_err(eb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: bank contents, "scanning" flag, current index, pulses.
  logic [15:0] mreg  [2][14];
  bit          mscan [2];
  int          midx  [2];
  bit          mdone [2];
  bit          merr  [2];

  task automatic model_step(input int k);
    int last;
    last = (k == 0) ? 13 : 4;
    if (rst) begin
      for (int i = 0; i < 14; i++) mreg[k][i] = 16'h0;
      mscan[k] = 0; midx[k] = 0; mdone[k] = 0; merr[k] = 0;
    end else begin
      merr[k] = wr_en && ((wr_addr >= 4'd14) || mscan[k]);
      if (wr_en && (wr_addr < 4'd14) && !mscan[k]) mreg[k][wr_addr] = wr_data;
      mdone[k] = 0;
      if (!mscan[k]) begin
        if (start) begin mscan[k] = 1; midx[k] = 0; end
      end else if (abort) begin
        mscan[k] = 0; midx[k] = 0;
      end else if (ready) begin
        if (midx[k] == last) begin mscan[k] = 0; midx[k] = 0; mdone[k] = 1; end
        else midx[k] = midx[k] + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 14; i++) begin
        chk($sformatf("a_reg%0d", i), ra[i], mreg[0][i]);
        chk($sformatf("b_reg%0d", i), rb[i], mreg[1][i]);
      end
      chk("a_sel", sela, midx[0]);   chk("b_sel", selb, midx[1]);
      chk("a_valid", va, mscan[0]);  chk("b_valid", vb, mscan[1]);
      chk("a_busy", ba, mscan[0]);   chk("b_busy", bb, mscan[1]);
      chk("a_done", da, mdone[0]);   chk("b_done", db, mdone[1]);
      chk("a_wr_err", ea, merr[0]);  chk("b_wr_err", eb, merr[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel_a(input int s);
    int n;
    n = 0;
    while (!(va && (sela == 4'(s))) && (n < 40)) begin
      tick();
      n++;
    end
    chk($sformatf("wait_a_sel%0d", s), {va, sela}, {1'b1, 4'(s)});
  endtask

  initial begin
    int nval, done_cyc, hold, nsel5, done_first, ndone;
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; abort = 0; ready = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 14; i++) mreg[k][i] = 16'h0;
      mscan[k] = 0; midx[k] = 0; mdone[k] = 0; merr[k] = 0;
    end
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    chk("rst_sel", sela, 0); chk("rst_valid", va, 0); chk("rst_busy", ba, 0);
    chk("rst_reg7", ra[7], 0);

    // Writes after reset.
    wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5;
    tick();
    wr_addr = 13; wr_data = 16'h1234;
    tick();
    wr_en = 0;
    chk("wr_reg3", ra[3], 16'hA5A5); chk("wr_reg13", ra[13], 16'h1234);
    chk("wr_reg4", ra[4], 0);        chk("wr_err_ok", ea, 0);

    // Bad addresses.
    wr_en = 1; wr_addr = 14; wr_data = 16'hFFFF;
    tick();
    chk("bad14_err", ea, 1);
    wr_addr = 15;
    tick();
    chk("bad15_err", ea, 1);
    wr_en = 0;
    tick();
    chk("bad_err_clr", ea, 0); chk("bad_reg3", ra[3], 16'hA5A5);

    // Load n*0x0101 into every register, with a random-data write first.
    for (int n = 0; n < 14; n++) begin
      wr_en = 1; wr_addr = 4'(n); wr_data = 16'($urandom);
      tick();
      wr_data = 16'(n * 16'h0101);
      tick();
    end
    wr_en = 0;

    // Full scan, ready tied high.
    ready = 1; start = 1;
    tick();
    start = 0;
    nval = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (va) begin
        nval++;
        chk("scan_sel", sela, cyc - 1);
        chk("scan_data", ra[sela], 16'(sela * 16'h0101));
      end
      if (da) done_cyc = cyc;
      tick();
    end
    chk("scan_nvalid", nval, 14); chk("scan_done_cyc", done_cyc, 15);
    chk("scan_idle_sel", sela, 0);

    // Backpressure at sel=5 for 3 cycles.
    start = 1;
    tick();
    start = 0;
    nval = 0; done_cyc = 0; hold = 0; nsel5 = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (va) nval++;
      if (va && sela == 4'd5) nsel5++;
      if (da) done_cyc = cyc;
      if (va && sela == 4'd5 && hold < 3) begin ready = 0; hold++; end
      else ready = 1;
      tick();
    end
    chk("bp_nvalid", nval, 17); chk("bp_sel5_cycles", nsel5, 4);
    chk("bp_done_cyc", done_cyc, 18);

    // Write during scan, then abort at sel=7.
    ready = 1; start = 1;
    tick();
    start = 0;
    wait_sel_a(2);
    wr_en = 1; wr_addr = 1; wr_data = 16'hBEEF;
    tick();
    wr_en = 0;
    chk("wscan_err", ea, 1); chk("wscan_reg1", ra[1], 16'h0101);
    wait_sel_a(7);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_valid", va, 0); chk("abort_busy", ba, 0);
    chk("abort_sel", sela, 0); chk("abort_done", da, 0);
    tick();
    chk("abort_done2", da, 0);
    repeat (4) tick();

    // Back-to-back scans on the LAST_SEL=4 instance with start held high.
    start = 1; ready = 1;
    tick();
    nval = 0; done_first = 0; ndone = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (vb) begin
        nval++;
        chk("b2b_sel", selb, (cyc - 1) % 6);
      end
      if (db) begin
        ndone++;
        if (done_first == 0) done_first = cyc;
      end
      tick();
    end
    start = 0;
    chk("b2b_nvalid", nval, 12); chk("b2b_done_first", done_first, 6);
    chk("b2b_ndone", ndone, 2);
    repeat (10) tick();

    // Random idle-time writes and ready jitter, checked by the model.
    for (int r = 0; r < 60; r++) begin
      wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 16'($urandom);
      start = ($urandom_range(0, 7) == 0); abort = ($urandom_range(0, 15) == 0);
      ready = 1'($urandom);
      tick();
    end
    wr_en = 0; start = 0; abort = 0; ready = 1;
    repeat (20) tick();

    // Reset in the middle of a scan.
    start = 1;
    tick();
    start = 0;
    wait_sel_a(9);
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_sel", sela, 0); chk("mrst_valid", va, 0); chk("mrst_busy", ba, 0);
    chk("mrst_done", da, 0);  chk("mrst_err", ea, 0);   chk("mrst_reg13", ra[13], 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
